// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter granting one byte-stream requester at a time the UART TX write port.
// Latency: grant one cycle after req in IDLE, first write that same SEND cycle; one byte/cycle in a burst.
// Backpressure: tx_full stalls the burst with no strobes; UART_ARB_FIXED_PRIO_EN selects lowest-index priority.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        ack,
    input  logic                      tx_full,
    output logic                      wr_uart,
    output logic [DATA_W-1:0]         w_data,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ID_W-1:0]   sel;
    logic              sel_vld;
    logic              cur_req;
    logic              cur_last;
    logic              beat;
    logic              burst_end;

    // Offset from the round-robin pointer, folded back into 0..NUM_REQ-1.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel     = ID_W'(i);
                sel_vld = 1'b1;
            end
        end
`else
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!sel_vld && req[wrap_idx(ptr_q, i)]) begin
                sel     = wrap_idx(ptr_q, i);
                sel_vld = 1'b1;
            end
        end
`endif
    end

    assign cur_req   = req[gnt_q];
    assign cur_last  = req_last[gnt_q];
    assign beat      = (state_q == SEND) && cur_req && !tx_full;
    assign burst_end = (state_q == SEND) &&
                       ((beat && (cur_last || (cnt_q == CNT_LAST))) || !cur_req);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_uart = 1'b0;
        w_data  = '0;
        ack     = '0;

        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    gnt_d   = sel;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (beat) begin
                    wr_uart    = 1'b1;
                    w_data     = req_data[gnt_q*DATA_W +: DATA_W];
                    ack[gnt_q] = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
                if (burst_end) begin
                    state_d = IDLE;
`ifdef UART_ARB_FIXED_PRIO_EN
                    ptr_d   = '0;
`else
                    ptr_d   = (gnt_q == ID_MAX) ? '0 : gnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // A burst aborted by reset must not push a byte into the FIFO.
        if (Reset) begin
            wr_uart = 1'b0;
            w_data  = '0;
            ack     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_valid = (state_q == SEND);
    assign grant_id    = gnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester models feed queued bytes, a monitor checks every write.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk;
    logic            Reset;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   ack;
    logic            tx_full;
    logic            wr_uart;
    logic [DW-1:0]   w_data;
    logic            grant_valid;
    logic [1:0]      grant_id;

    uart_tx_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .ack         (ack),
        .tx_full     (tx_full),
        .wr_uart     (wr_uart),
        .w_data      (w_data),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] rq_d [NR][$];
    logic       rq_l [NR][$];
    int         exp_id [$];
    logic [7:0] exp_d  [$];
    int         wr_log [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic give(input int r, input int d, input bit l);
        rq_d[r].push_back(8'(d));
        rq_l[r].push_back(l);
    endtask

    task automatic expect_b(input int r, input int d);
        exp_id.push_back(r);
        exp_d.push_back(8'(d));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_id.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", exp_id.size(), 0);
    endtask

    task automatic chk_offsets(input string nm, input int c0, input int offs[$]);
        chk({nm, "_count"}, wr_log.size(), offs.size());
        for (int j = 0; j < offs.size(); j++) begin
            if (j < wr_log.size()) chk({nm, "_cycle"}, wr_log[j] - c0, offs[j]);
        end
    endtask

    // Requester models: present the head byte, pop it on the cycle after ack.
    initial begin
        logic [NR-1:0] ack_s;
        req = '0;
        req_data = '0;
        req_last = '0;
        forever begin
            @(negedge clk);
            ack_s = ack;
            @(posedge clk);
            for (int i = 0; i < NR; i++) begin
                if (ack_s[i] && rq_d[i].size() > 0) begin
                    void'(rq_d[i].pop_front());
                    void'(rq_l[i].pop_front());
                end
            end
            #2;
            for (int i = 0; i < NR; i++) begin
                if (rq_d[i].size() > 0) begin
                    req[i]            = 1'b1;
                    req_data[i*DW +: DW] = rq_d[i][0];
                    req_last[i]       = rq_l[i][0];
                end else begin
                    req[i]            = 1'b0;
                    req_data[i*DW +: DW] = '0;
                    req_last[i]       = 1'b0;
                end
            end
        end
    end

    // Monitor: every write must match the next expected (requester, byte).
    initial begin
        int         id;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (wr_uart) begin
                chk("wr_while_full", tx_full, 0);
                if (exp_id.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write got=%0h id=%0d want=none", w_data, grant_id);
                end else begin
                    id = exp_id.pop_front();
                    d  = exp_d.pop_front();
                    chk("w_data", w_data, d);
                    chk("grant_id", grant_id, id);
                    chk("ack_onehot", ack, 32'(1 << id));
                    chk("gv_on_write", grant_valid, 1);
                    wr_log.push_back(cyc);
                end
            end else begin
                chk("ack_without_write", ack, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int offs[$];
        Reset   = 1'b1;
        tx_full = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        sample();
        chk("rst_wr_uart", wr_uart, 0);
        chk("rst_ack", ack, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_id", grant_id, 0);

`ifdef UART_ARB_FIXED_PRIO_EN
        // Requesters 1 and 3 held: 1 keeps winning until it runs dry.
        tick();
        c0 = cyc;
        wr_log.delete();
        for (int k = 0; k < 12; k++) give(1, 8'h70 + k, 1'b0);
        for (int k = 0; k < 4; k++)  give(3, 8'h90 + k, k == 3);
        for (int k = 0; k < 12; k++) expect_b(1, 8'h70 + k);
        for (int k = 0; k < 4; k++)  expect_b(3, 8'h90 + k);
        drain(100);
        offs.delete();
        for (int j = 0; j < 16; j++) offs.push_back(1 + j + j / 4);
        chk_offsets("fixed", c0, offs);
`else
        // Round robin: all four pending, two full bursts each.
        tick();
        c0 = cyc;
        wr_log.delete();
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < 8; k++) give(r, r * 16 + k, 1'b0);
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < NR; r++)
                for (int k = 0; k < 4; k++) expect_b(r, r * 16 + b * 4 + k);
        drain(200);
        offs.delete();
        for (int j = 0; j < 32; j++) offs.push_back(1 + j + j / 4);
        chk_offsets("rr", c0, offs);

        // Single message from requester 2 (pointer is back at 0).
        tick();
        give(2, 8'h41, 1'b0);
        give(2, 8'h42, 1'b0);
        give(2, 8'h43, 1'b1);
        expect_b(2, 8'h41);
        expect_b(2, 8'h42);
        expect_b(2, 8'h43);
        sample();
        chk("single_idle_gv", grant_valid, 0);
        chk("single_idle_wr", wr_uart, 0);
        for (int j = 0; j < 3; j++) begin
            tick();
            sample();
            chk("single_wr", wr_uart, 1);
            chk("single_ack", ack, 4'b0100);
        end
        tick();
        sample();
        chk("single_end_gv", grant_valid, 0);

        // Pointer now 3: of {0,3}, requester 3 goes first.
        tick();
        give(0, 8'h0A, 1'b1);
        give(3, 8'h3A, 1'b1);
        expect_b(3, 8'h3A);
        expect_b(0, 8'h0A);
        drain(20);

        // Backpressure mid-burst of requester 1; last lands on the count limit.
        tick();
        c0 = cyc;
        wr_log.delete();
        for (int k = 0; k < 4; k++) begin
            give(1, 8'h10 + k, k == 3);
            expect_b(1, 8'h10 + k);
        end
        sample();
        tick();
        sample();
        tick();
        sample();
        tick();
        tx_full = 1'b1;
        sample();
        chk("bp_no_wr", wr_uart, 0);
        chk("bp_gv", grant_valid, 1);
        for (int j = 0; j < 4; j++) begin
            tick();
            sample();
            chk("bp_no_wr", wr_uart, 0);
            chk("bp_no_ack", ack, 0);
        end
        tick();
        tx_full = 1'b0;
        drain(20);
        offs.delete();
        offs.push_back(1);
        offs.push_back(2);
        offs.push_back(8);
        offs.push_back(9);
        chk_offsets("bp", c0, offs);
        tick();
        sample();
        chk("bp_end_gv", grant_valid, 0);

        // Withdrawal: requester 0 stops after two bytes, requester 1 follows.
        tick();
        c0 = cyc;
        wr_log.delete();
        give(0, 8'h01, 1'b0);
        give(0, 8'h02, 1'b0);
        give(1, 8'h21, 1'b1);
        expect_b(0, 8'h01);
        expect_b(0, 8'h02);
        expect_b(1, 8'h21);
        drain(30);
        offs.delete();
        offs.push_back(1);
        offs.push_back(2);
        offs.push_back(5);
        chk_offsets("wd", c0, offs);

        // Reset after one byte of requester 3; pointer must restart at 0.
        tick();
        give(3, 8'h51, 1'b0);
        give(3, 8'h52, 1'b0);
        give(3, 8'h53, 1'b1);
        expect_b(3, 8'h51);
        sample();
        tick();
        sample();
        chk("rmb_first_wr", wr_uart, 1);
        tick();
        Reset = 1'b1;
        give(1, 8'h61, 1'b1);
        expect_b(1, 8'h61);
        expect_b(3, 8'h52);
        expect_b(3, 8'h53);
        sample();
        chk("rmb_no_wr", wr_uart, 0);
        chk("rmb_no_ack", ack, 0);
        tick();
        Reset = 1'b0;
        sample();
        chk("rmb_gv", grant_valid, 0);
        chk("rmb_gid", grant_id, 0);
        chk("rmb_wr", wr_uart, 0);
        chk("rmb_ack", ack, 0);
        chk("rmb_wdata", w_data, 0);
        drain(30);
`endif

        tick();
        sample();
        chk("end_idle_gv", grant_valid, 0);
        chk("end_idle_req", req, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
